// File: rtl/l_stf_pkg.sv
// l_stf_pkg: shared definitions for the L-STF preamble sequencer.
//   - sequencer state encoding
//   - ROM geometry (16 entries, 4-bit address) and repetition counter width
//   - default number of ROM passes
//   - I/Q field positions inside a packed 32-bit sample {I[31:16], Q[15:0]}
//   - half_iq(): per-component arithmetic shift right by one (first-sample window)
package l_stf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } l_stf_state_t;

  localparam int unsigned L_STF_ROM_DEPTH = 16;
  localparam int unsigned L_STF_ADDR_W    = 4;
  localparam int unsigned L_STF_REP_W     = 4;
  localparam int unsigned L_STF_NUM_REP   = 10;

  localparam int unsigned L_STF_I_MSB = 31;
  localparam int unsigned L_STF_I_LSB = 16;
  localparam int unsigned L_STF_Q_MSB = 15;
  localparam int unsigned L_STF_Q_LSB = 0;

  // Halve both components, sign-preserving and truncating toward -inf.
  function automatic logic [31:0] half_iq(input logic [31:0] s);
    logic signed [15:0] i_s;
    logic signed [15:0] q_s;
    i_s = s[L_STF_I_MSB:L_STF_I_LSB];
    q_s = s[L_STF_Q_MSB:L_STF_Q_LSB];
    return {i_s >>> 1, q_s >>> 1};
  endfunction

endpackage

// File: rtl/l_stf_seq.sv
// l_stf_seq: legacy short training field sequencer.
// Walks the external 16-entry L-STF ROM cyclically NUM_REP times and streams
// each sample to the TX sample path over a valid/ready handshake.
//
// Ports:
//   clk            TX clock
//   phy_tx_arestn  synchronous active-low reset
//   start          one-cycle request to begin a field (honoured in IDLE only)
//   abort          synchronous cancel, returns to IDLE from any state
//   busy           field in progress
//   done           one-cycle pulse after the final sample handshake
//   rom_addr       address to the external combinational L-STF ROM
//   rom_dout       ROM sample {I[31:16], Q[15:0]}
//   tx_data        output sample, same packing
//   tx_valid       tx_data holds a valid sample
//   tx_ready       downstream accepts when tx_valid && tx_ready
//
// Build option:
//   L_STF_WINDOW_EN  halve I and Q of the very first sample of each field.
module l_stf_seq
  import l_stf_pkg::*;
#(
  parameter int unsigned NUM_REP = L_STF_NUM_REP
) (
  input  logic                    clk,
  input  logic                    phy_tx_arestn,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [L_STF_ADDR_W-1:0] rom_addr,
  input  logic [31:0]             rom_dout,
  output logic [31:0]             tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  localparam logic [L_STF_ADDR_W-1:0] LAST_ADDR = L_STF_ADDR_W'(L_STF_ROM_DEPTH - 1);
  localparam logic [L_STF_REP_W-1:0]  LAST_REP  = L_STF_REP_W'(NUM_REP - 1);

  l_stf_state_t           state;
  logic [L_STF_REP_W-1:0] rep;
  logic                   load_en;
  logic [31:0]            sample;

  // Output register is free when empty or being drained this cycle.
  assign load_en = !tx_valid || tx_ready;
  assign busy    = (state != IDLE);

`ifdef L_STF_WINDOW_EN
  assign sample = (rom_addr == '0 && rep == '0) ? half_iq(rom_dout) : rom_dout;
`else
  assign sample = rom_dout;
`endif

  always_ff @(posedge clk) begin
    if (!phy_tx_arestn) begin
      state    <= IDLE;
      rom_addr <= '0;
      rep      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      rom_addr <= '0;
      rep      <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rom_addr <= '0;
          rep      <= '0;
          tx_valid <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (load_en) begin
            tx_data  <= sample;
            tx_valid <= 1'b1;
            rom_addr <= rom_addr + 1'b1;
            if (rom_addr == LAST_ADDR) begin
              // Last sample loaded: wait for its handshake in DRAIN.
              if (rep == LAST_REP) state <= DRAIN;
              else                 rep   <= rep + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            rom_addr <= '0;
            rep      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l_stf_seq.sv
module tb_l_stf_seq;
  import l_stf_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start, abort, tx_ready;
  logic        busy, done, tx_valid;
  logic [3:0]  rom_addr;
  logic [31:0] rom_dout, tx_data;

  logic        start1, abort1, tx_ready1;
  logic        busy1, done1, tx_valid1;
  logic [3:0]  rom_addr1;
  logic [31:0] rom_dout1, tx_data1;

  logic [31:0] rom [16];
  assign rom_dout  = rom[rom_addr];
  assign rom_dout1 = rom[rom_addr1];

  int checks   = 0;
  int failures = 0;

  l_stf_seq #(.NUM_REP(10)) u_dut (
    .clk(clk), .phy_tx_arestn(rstn), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  l_stf_seq #(.NUM_REP(1)) u_dut1 (
    .clk(clk), .phy_tx_arestn(rstn), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int floor_half(input int v);
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  // Reference: global sample k is ROM[k mod 16]; optionally only k==0 is halved.
  function automatic logic [31:0] exp_sample(input int k);
    logic [31:0] s;
    int iv, qv;
    s  = rom[k % 16];
    iv = int'($signed(s[31:16]));
    qv = int'($signed(s[15:0]));
`ifdef L_STF_WINDOW_EN
    if (k == 0) begin
      iv = floor_half(iv);
      qv = floor_half(qv);
    end
`endif
    s = {iv[15:0], qv[15:0]};
    return s;
  endfunction

  task automatic check_seq(input string name, input logic [31:0] q[$], input int n);
    chk({name, "_count"}, q.size(), n);
    foreach (q[i]) chk({name, "_sample"}, q[i], exp_sample(i));
  endtask

  // Drives one field on u_dut and collects every handshaken sample.
  task automatic run_field(input bit rnd, input int abort_at, input int mid_start_cyc,
                           input bit restart_in_done, input bit pre_started,
                           output logic [31:0] q[$]);
    int          cyc = 0;
    int          vcyc = 0;
    bit          stalled = 0;
    logic [31:0] prev = '0;
    q.delete();
    if (!pre_started) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("busy_after_start", busy, 32'd1);
    chk("valid_after_start", tx_valid, 32'd0);
    while (cyc < 2000) begin
      cyc++;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (cyc == mid_start_cyc);
      abort    = 1'b0;
      if (abort_at >= 0 && q.size() == abort_at) begin
        abort    = 1'b1;
        tx_ready = 1'b0;
      end
      if (stalled) begin
        chk("hold_valid", tx_valid, 32'd1);
        chk("hold_data", tx_data, prev);
      end
      chk("no_early_done", done, 32'd0);
      stalled = tx_valid && !tx_ready;
      prev    = tx_data;
      if (tx_valid) vcyc++;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      step();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk("abort_valid", tx_valid, 32'd0);
        chk("abort_busy", busy, 32'd0);
        chk("abort_addr", rom_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
          chk("abort_no_done", done, 32'd0);
          step();
        end
        return;
      end
      if (q.size() == 160) begin
        chk("done_pulse", done, 32'd1);
        chk("busy_fall", busy, 32'd0);
        chk("valid_fall", tx_valid, 32'd0);
        if (!rnd) chk("valid_cycles", vcyc, 32'd160);
        if (restart_in_done) begin
          start = 1'b1;
          step();
          start = 1'b0;
        end else begin
          tx_ready = 1'b0;
          step();
          chk("done_one_cycle", done, 32'd0);
        end
        return;
      end
    end
    chk("field_timeout", cyc, 32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } vec_t;

  initial begin
    logic [31:0] q[$];
    logic [31:0] q1[$];
    vec_t        vec[5];
    int          c1;

    rom[0]  = 32'h05E305E3; rom[1]  = 32'hEF0C004D; rom[2]  = 32'hFE56F5E3; rom[3]  = 32'h124EFE56;
    rom[4]  = 32'h0BC70000; rom[5]  = 32'h124EFE56; rom[6]  = 32'hFE56F5E3; rom[7]  = 32'hEF0C004D;
    rom[8]  = 32'h05E305E3; rom[9]  = 32'h004DEF0C; rom[10] = 32'hF5E3FE56; rom[11] = 32'hFE56124E;
    rom[12] = 32'h00000BC7; rom[13] = 32'hFE56124E; rom[14] = 32'hF5E3FE56; rom[15] = 32'h004DEF0C;

`ifdef L_STF_WINDOW_EN
    vec[0] = '{0, 32'h02F102F1};
`else
    vec[0] = '{0, 32'h05E305E3};
`endif
    vec[1] = '{1,   32'hEF0C004D};
    vec[2] = '{15,  32'h004DEF0C};
    vec[3] = '{16,  32'h05E305E3};
    vec[4] = '{159, 32'h004DEF0C};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; tx_ready1 = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_valid", tx_valid, 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_addr", rom_addr, 32'd0);
    rstn = 1'b1;
    step();

    // Full-rate field
    run_field(1'b0, -1, -1, 1'b0, 1'b0, q);
    check_seq("full", q, 160);
    for (int i = 0; i < 5; i++)
      if (q.size() > vec[i].idx) chk("vec_sample", q[vec[i].idx], vec[i].exp);
      else chk("vec_missing", q.size(), vec[i].idx + 1);

    // Random back-pressure
    run_field(1'b1, -1, -1, 1'b0, 1'b0, q);
    check_seq("rand", q, 160);

    // Abort at sample 37, then restart from sample 0
    run_field(1'b0, 37, -1, 1'b0, 1'b0, q);
    check_seq("abort", q, 37);
    run_field(1'b0, -1, -1, 1'b0, 1'b0, q);
    check_seq("after_abort", q, 160);
    if (q.size() > 0) chk("restart_s0", q[0], vec[0].exp);

    // Start during RUN ignored; start in done cycle begins a new field
    run_field(1'b1, -1, 50, 1'b1, 1'b0, q);
    check_seq("mid_start", q, 160);
    run_field(1'b0, -1, -1, 1'b0, 1'b1, q);
    check_seq("b2b", q, 160);

    // NUM_REP=1 instance: 16 samples then done
    q1.delete();
    start1 = 1'b1; step(); start1 = 1'b0;
    tx_ready1 = 1'b1;
    c1 = 0;
    while (q1.size() < 16 && c1 < 100) begin
      c1++;
      chk("rep1_no_early_done", done1, 32'd0);
      if (tx_valid1) q1.push_back(tx_data1);
      step();
    end
    chk("rep1_done", done1, 32'd1);
    chk("rep1_busy", busy1, 32'd0);
    check_seq("rep1", q1, 16);
    if (q1.size() == 16) chk("rep1_last", q1[15], 32'h004DEF0C);
    tx_ready1 = 1'b0;
    step();
    chk("rep1_done_once", done1, 32'd0);

    // Reset mid-field clears tx_data as well
    start = 1'b1; step(); start = 1'b0;
    tx_ready = 1'b1;
    repeat (10) step();
    rstn = 1'b0;
    step();
    chk("midrst_valid", tx_valid, 32'd0);
    chk("midrst_data", tx_data, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_done", done, 32'd0);
    rstn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l_stf_seq.md
# l_stf_seq

Sequencer for the legacy short training field (L-STF) of the OFDM transmit preamble. It walks the 16-entry L-STF sample ROM cyclically for a configurable number of repetitions and streams the samples to the TX sample path over a valid/ready handshake. It sits between the PHY TX control FSM (start/abort/done) and the preamble/sample mux feeding the IFFT-bypass output.

## Interface
Parameters:
- NUM_REP, 10, number of 16-sample ROM passes; total samples = 16*NUM_REP; legal range 1..15.

Ports:
- clk  in  1  TX clock; single clock domain.
- phy_tx_arestn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin the field; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns the block to IDLE from any state.
- busy  out  1  high from the cycle after accepted start until the final handshake or an abort.
- done  out  1  one-cycle pulse after the last sample handshake; not asserted on abort.
- rom_addr  out  4  address to the external combinational L-STF ROM.
- rom_dout  in  32  ROM sample, {I[31:16], Q[15:0]}, each signed 16-bit.
- tx_data  out  32  output sample, same packing.
- tx_valid  out  1  tx_data holds a valid sample.
- tx_ready  in  1  downstream accepts when tx_valid && tx_ready.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: rom_addr=0, rep counter=0, tx_valid=0. start && !abort -> RUN.
- RUN: load_en = !tx_valid || tx_ready. On load_en: tx_data <= rom_dout (ROM at current rom_addr), tx_valid <= 1, rom_addr increments modulo 16; on wrap 15->0 the rep counter increments. Loading the sample at rom_addr=15 with rep=NUM_REP-1 -> DRAIN.
- DRAIN: hold the last sample; on tx_ready -> tx_valid<=0, done<=1, -> IDLE.
- Back-pressure: with tx_ready low, tx_data, tx_valid, rom_addr and counters hold.
- abort has priority over start and over every state transition: next cycle state=IDLE, tx_valid=0, busy=0, done=0, counters=0.
- start while busy: ignored.
- Sample order: ROM index 0..15 repeated NUM_REP times, no gaps and no duplicates regardless of tx_ready pattern.
- Counters: 4-bit rom_addr, 4-bit rep counter; no other arithmetic except the optional window.

## Timing
- Reset values: busy=0, done=0, tx_valid=0, tx_data=0, rom_addr=0, state IDLE.
- Latency: start registered at edge k -> tx_valid=1 with sample 0 after edge k+1.
- Throughput: one sample per cycle with tx_ready held high; 160 samples in 160 consecutive cycles for NUM_REP=10.
- done is high for exactly one cycle, following the edge that completes the final handshake; busy falls on the same edge.
- Back-to-back fields: start is accepted in the cycle done is high, since the state is already IDLE.
- Reset mid-field behaves as abort and additionally clears tx_data.

## Configuration
- L_STF_WINDOW_EN defined: the first sample of each field (global index 0 only) is windowed. I and Q are each arithmetic-shifted right by 1, sign-preserving, truncating. Example: 0x05E305E3 -> 0x02F102F1.
- L_STF_WINDOW_EN undefined: all samples pass unmodified.
- Latency and handshake are identical in both builds.

## Structure
- Shared package l_stf_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the ROM depth constant (16) and address width (4);
  - the default NUM_REP (10);
  - the I/Q field slice constants.
- No internal sub-module. The l_stf_rom instance lives in the parent and connects through rom_addr/rom_dout.

## Test plan
- Reset, then one start pulse, tx_ready=1: 160 samples in 160 cycles; sample 0 = 0x05E305E3, sample 1 = 0xEF0C004D, sample 16 = 0x05E305E3, sample 159 = 0x004DEF0C; done one cycle after the last; busy falls on the same edge.
- Random tx_ready (50% duty): the sample sequence matches ROM index i mod 16 exactly; tx_data stable while tx_valid && !tx_ready.
- abort asserted at sample 37: tx_valid=0 next cycle, no done; a following start restarts at sample 0 = 0x05E305E3.
- start pulsed during RUN and again in the done cycle: the first is ignored; the second begins a new 160-sample field immediately.
- NUM_REP=1: exactly 16 samples, the last being 0x004DEF0C, then done.
- Build with L_STF_WINDOW_EN: sample 0 = 0x02F102F1; sample 16 = 0x05E305E3 (unwindowed). Build without the macro: sample 0 = 0x05E305E3.
